prim_clock_sel_ctrl: RTL and testbench



---
 rtl/prim_clock_sel_pkg.sv | 22 ++
 rtl/prim_clock_sel_cnt.sv | 42 ++++
 rtl/prim_clock_sel_ctrl.sv | 166 ++++++++++++++++
 tb/tb_prim_clock_sel_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_clock_sel_pkg.sv
// Shared types and defaults for the clock-select sequencer.
// Optional feature macro used by the consumers of this package:
//   PRIM_CLK_SEL_TIMEOUT_EN - bounds the QUIESCE wait and flags err_o.
package prim_clock_sel_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUIESCE = 3'd1,
        SWITCH  = 3'd2,
        SETTLE  = 3'd3,
        ACK     = 3'd4
    } sel_state_e;

    localparam int unsigned DefaultSettleCycles  = 8;
    localparam int unsigned DefaultTimeoutCycles = 64;

    // Bits needed to hold the value n, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/prim_clock_sel_cnt.sv
// Loadable down-counter shared by the settle and quiesce-timeout counts.
// done_o is high while the count reads 1, i.e. on the last counted cycle.
module prim_clock_sel_cnt
    import prim_clock_sel_pkg::*;
#(
    parameter int unsigned Width = cnt_width(DefaultSettleCycles)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Next count: load wins over decrement; the count saturates at zero.
    always_comb begin
        // NOTE: assign every always_comb output first so no path can infer a latch.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == Width'(1));

endmodule

// File: rtl/prim_clock_sel_ctrl.sv
// Select sequencer for a two-input clock mux: gates the consumer with
// clk_en_o, waits for idle_i, flips sel_o, settles, then pulses ack_o.
// Optional: define PRIM_CLK_SEL_TIMEOUT_EN to bound the QUIESCE wait to
// TimeoutCycles and raise the sticky err_o when the bound forces a switch.
module prim_clock_sel_ctrl
    import prim_clock_sel_pkg::*;
#(
    parameter int unsigned SettleCycles  = DefaultSettleCycles,
    parameter logic        ResetSel      = 1'b0,
    parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic req_sel_i,
    input  logic idle_i,
    output logic sel_o,
    output logic clk_en_o,
    output logic busy_o,
    output logic ack_o,
    output logic err_o
);

    localparam int unsigned SettleW = cnt_width(SettleCycles);
`ifdef PRIM_CLK_SEL_TIMEOUT_EN
    localparam int unsigned TimeoutW = cnt_width(TimeoutCycles);
    localparam int unsigned CntW     = (SettleW > TimeoutW) ? SettleW : TimeoutW;
`else
    localparam int unsigned CntW     = SettleW;
`endif

    sel_state_e state_q;
    logic       sel_q;
    logic       target_q;
    logic       clk_en_q;
    logic       busy_q;
    logic       ack_q;

    logic            cnt_load;
    logic [CntW-1:0] cnt_load_val;
    logic            cnt_dec;
    logic            cnt_done;

    // Counter control: settle count is loaded leaving SWITCH; with the
    // timeout enabled the quiesce budget is loaded when a switch is accepted.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        unique case (state_q)
            SWITCH: begin
                cnt_load     = (SettleCycles != 0);
                cnt_load_val = CntW'(SettleCycles);
            end
            SETTLE: cnt_dec = 1'b1;
`ifdef PRIM_CLK_SEL_TIMEOUT_EN
            IDLE: begin
                cnt_load     = req_i && (req_sel_i != sel_q);
                cnt_load_val = CntW'(TimeoutCycles);
            end
            QUIESCE: cnt_dec = 1'b1;
`endif
            default: ;
        endcase
    end

    prim_clock_sel_cnt #(
        .Width (CntW)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

`ifdef PRIM_CLK_SEL_TIMEOUT_EN
    logic err_q;

    // Sticky timeout flag: set when the quiesce budget forces the switch,
    // cleared by the next accepted request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && req_i) begin
            err_q <= 1'b0;
        end else if (state_q == QUIESCE && !idle_i && cnt_done) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Sequencer FSM; outputs are registered alongside the state so they
    // change on the same edge as the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sel_q    <= ResetSel;
            target_q <= ResetSel;
            clk_en_q <= 1'b1;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_i) begin
                        busy_q <= 1'b1;
                        if (req_sel_i != sel_q) begin
                            target_q <= req_sel_i;
                            clk_en_q <= 1'b0;
                            state_q  <= QUIESCE;
                        end else begin
                            ack_q   <= 1'b1;
                            state_q <= ACK;
                        end
                    end
                end
                QUIESCE: begin
`ifdef PRIM_CLK_SEL_TIMEOUT_EN
                    if (idle_i || cnt_done) begin
                        state_q <= SWITCH;
                    end
`else
                    if (idle_i) begin
                        state_q <= SWITCH;
                    end
`endif
                end
                SWITCH: begin
                    sel_q <= target_q;
                    if (SettleCycles == 0) begin
                        ack_q    <= 1'b1;
                        clk_en_q <= 1'b1;
                        state_q  <= ACK;
                    end else begin
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_done) begin
                        ack_q    <= 1'b1;
                        clk_en_q <= 1'b1;
                        state_q  <= ACK;
                    end
                end
                ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel_o    = sel_q;
    assign clk_en_o = clk_en_q;
    assign busy_o   = busy_q;
    assign ack_o    = ack_q;

endmodule

// File: tb/tb_prim_clock_sel_ctrl.sv
// Self-checking bench for prim_clock_sel_ctrl: a timeline model predicts
// every output each cycle, and directed sections pin literal latencies.
// Follows PRIM_CLK_SEL_TIMEOUT_EN when it is defined for the build.
module tb_prim_clock_sel_ctrl;

    localparam int unsigned Settle    = 8;
    localparam logic        ResetSelP = 1'b0;
    localparam int unsigned Timeout   = 64;
`ifdef PRIM_CLK_SEL_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic clk_i     = 1'b0;
    logic rst_i     = 1'b0;
    logic req_i     = 1'b0;
    logic req_sel_i = 1'b0;
    logic idle_i    = 1'b1;
    logic sel_o, clk_en_o, busy_o, ack_o, err_o;

    int checks   = 0;
    int errors   = 0;
    bit check_en = 1'b0;

    always #5 clk_i = ~clk_i;

    prim_clock_sel_ctrl #(
        .SettleCycles  (Settle),
        .ResetSel      (ResetSelP),
        .TimeoutCycles (Timeout)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .req_sel_i (req_sel_i),
        .idle_i    (idle_i),
        .sel_o     (sel_o),
        .clk_en_o  (clk_en_o),
        .busy_o    (busy_o),
        .ack_o     (ack_o),
        .err_o     (err_o)
    );

    task automatic check(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Model: once a switch leaves the quiesce wait at edge q, the select
    // moves at q+1, the ack is due at q+1+Settle and busy drops one edge later.
    int cyc      = 0;
    bit m_sel    = ResetSelP;
    bit m_clk_en = 1'b1;
    bit m_busy   = 1'b0;
    bit m_ack    = 1'b0;
    bit m_err    = 1'b0;
    bit m_wait   = 1'b0;
    bit m_pend   = 1'b0;
    int m_qcyc   = 0;
    int m_sel_at = -1;
    int m_ack_at = -1;
    int m_end_at = -1;

    always @(posedge clk_i) begin
        cyc++;
        if (rst_i) begin
            m_sel = ResetSelP; m_clk_en = 1'b1; m_busy = 1'b0; m_ack = 1'b0;
            m_err = 1'b0; m_wait = 1'b0;
            m_sel_at = -1; m_ack_at = -1; m_end_at = -1;
        end else begin
            m_ack = 1'b0;
            if (!m_busy) begin
                if (req_i) begin
                    m_busy = 1'b1; m_err = 1'b0;
                    m_sel_at = -1; m_ack_at = -1; m_end_at = -1;
                    if (req_sel_i != m_sel) begin
                        m_pend = req_sel_i; m_clk_en = 1'b0; m_wait = 1'b1; m_qcyc = 0;
                    end else begin
                        m_ack = 1'b1; m_end_at = cyc + 1;
                    end
                end
            end else if (m_wait) begin
                m_qcyc++;
                if (idle_i || (TimeoutEn && m_qcyc == int'(Timeout))) begin
                    if (!idle_i) m_err = 1'b1;
                    m_wait   = 1'b0;
                    m_sel_at = cyc + 1;
                    m_ack_at = cyc + 1 + int'(Settle);
                    m_end_at = m_ack_at + 1;
                end
            end else begin
                if (cyc == m_sel_at) m_sel = m_pend;
                if (cyc == m_ack_at) begin m_ack = 1'b1; m_clk_en = 1'b1; end
                if (cyc == m_end_at) m_busy = 1'b0;
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk_i) begin
        if (check_en) begin
            check("model_sel",    sel_o,    m_sel);
            check("model_clk_en", clk_en_o, m_clk_en);
            check("model_busy",   busy_o,   m_busy);
            check("model_ack",    ack_o,    m_ack);
            check("model_err",    err_o,    m_err);
        end
    end

    task automatic wait_ack(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (ack_o === 1'b1) seen = 1'b1;
        end
        check("wait_ack", seen, 1'b1);
    endtask

    int idle_low_left = 0;

    initial begin
        // Reset state.
        rst_i = 1'b1;
        tick(2);
        check_en = 1'b1;
        check("rst_sel", sel_o, 1'b0);
        check("rst_clk_en", clk_en_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ack", ack_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        rst_i = 1'b0;
        tick(1);

        // Normal switch 0 -> 1 with idle_i already high.
        req_i = 1'b1; req_sel_i = 1'b1;
        tick(1);
        req_i = 1'b0;
        check("sw_clk_en_off", clk_en_o, 1'b0);
        check("sw_busy_on", busy_o, 1'b1);
        tick(1);
        check("sw_sel_hold", sel_o, 1'b0);
        tick(1);
        check("sw_sel_new", sel_o, 1'b1);
        check("sw_clk_en_settle", clk_en_o, 1'b0);
        tick(Settle - 1);
        check("sw_ack_not_early", ack_o, 1'b0);
        tick(1);
        check("sw_ack", ack_o, 1'b1);
        check("sw_clk_en_on", clk_en_o, 1'b1);
        check("sw_busy_in_ack", busy_o, 1'b1);
        // A request landing in the ACK cycle is dropped.
        req_i = 1'b1; req_sel_i = 1'b0;
        tick(1);
        req_i = 1'b0;
        check("sw_ack_single", ack_o, 1'b0);
        check("sw_busy_off", busy_o, 1'b0);
        tick(1);
        check("ack_cycle_req_dropped", busy_o, 1'b0);
        check("ack_cycle_sel_kept", sel_o, 1'b1);

        // No-op request: target equals current select.
        req_i = 1'b1; req_sel_i = 1'b1;
        tick(1);
        req_i = 1'b0;
        check("noop_ack", ack_o, 1'b1);
        check("noop_sel", sel_o, 1'b1);
        check("noop_clk_en", clk_en_o, 1'b1);
        tick(1);
        check("noop_ack_single", ack_o, 1'b0);
        check("noop_busy_off", busy_o, 1'b0);

        // Quiesce stall with requests fired while busy.
        idle_i = 1'b0; req_i = 1'b1; req_sel_i = 1'b0;
        tick(1);
        for (int i = 0; i < 20; i++) begin
            req_i = 1'($urandom_range(0, 1)); req_sel_i = 1'($urandom_range(0, 1));
            tick(1);
            check("stall_sel", sel_o, 1'b1);
            check("stall_clk_en", clk_en_o, 1'b0);
        end
        req_i = 1'b0; idle_i = 1'b1;
        tick(1);
        check("stall_sel_before_switch", sel_o, 1'b1);
        tick(1);
        check("stall_sel_switched", sel_o, 1'b0);
        wait_ack(20);
        tick(1);

        // Reset in the middle of SETTLE.
        req_i = 1'b1; req_sel_i = 1'b1;
        tick(1);
        req_i = 1'b0;
        tick(4);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check("midrst_sel", sel_o, ResetSelP);
        check("midrst_clk_en", clk_en_o, 1'b1);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_ack", ack_o, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("midrst_no_ack", ack_o, 1'b0);
        end

        // Quiesce timeout (or indefinite wait without the feature).
        idle_i = 1'b0; req_i = 1'b1; req_sel_i = 1'b1;
        tick(1);
        req_i = 1'b0;
        tick(Timeout - 1);
        check("to_err_before", err_o, 1'b0);
        check("to_sel_before", sel_o, 1'b0);
        tick(1);
        check("to_err_set", err_o, TimeoutEn);
        check("to_clk_en_off", clk_en_o, 1'b0);
        idle_i = 1'b1;
        wait_ack(30);
        tick(1);
        check("to_err_sticky", err_o, TimeoutEn);
        check("to_sel_after", sel_o, 1'b1);
        req_i = 1'b1; req_sel_i = 1'b1;
        tick(1);
        req_i = 1'b0;
        check("to_err_cleared", err_o, 1'b0);
        check("to_clear_ack", ack_o, 1'b1);
        tick(1);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 2000; i++) begin
            rst_i     = ($urandom_range(0, 299) == 0);
            req_i     = ($urandom_range(0, 3) == 0);
            req_sel_i = 1'($urandom_range(0, 1));
            if (idle_low_left > 0) begin
                idle_i = 1'b0;
                idle_low_left--;
            end else begin
                idle_i = 1'b1;
                if ($urandom_range(0, 19) == 0)
                    idle_low_left = int'($urandom_range(1, TimeoutEn ? 90 : 30));
            end
            tick(1);
        end
        rst_i = 1'b0; req_i = 1'b0; idle_i = 1'b1;
        tick(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
